// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode trap/mret sequencer driving the second CSR write port and fetch redirect.
// Optional feature: define CSR_TRAP_VECTORED_EN for vectored interrupt targets when mtvec[1:0]==2'b01.
module csr_trap_ctrl #(
    parameter logic [31:0] TIMER_CAUSE  = 32'h8000_0007,
    parameter logic [31:0] ECALL_CAUSE  = 32'd11,
    parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        div_busy_i,
    input  logic        int_flag_i,
    input  logic        global_int_en_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    localparam logic [31:0] A_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] A_MEPC    = 32'h0000_0341;
    localparam logic [31:0] A_MCAUSE  = 32'h0000_0342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MSTATUS,
        S_W_MCAUSE,
        S_ASSERT,
        S_MRET_MSTATUS,
        S_MRET_ASSERT
    } state_t;

    state_t      r_state;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic        r_kind;

    logic        w_idle;
    logic        w_int;
    logic        w_detect;
    logic [31:0] w_base;
    logic [31:0] w_trap_addr;
    logic [31:0] w_mstatus_trap;
    logic [31:0] w_mstatus_mret;

    assign w_idle   = (r_state == S_IDLE);
    // Interrupts wait for an in-flight divide so the divider never loses its result.
    assign w_int    = int_flag_i & global_int_en_i & ~div_busy_i;
    assign w_detect = ecall_i | ebreak_i | mret_i | w_int;
    assign w_base   = {csr_mtvec_i[31:2], 2'b00};

    // Trap entry saves MIE into MPIE and clears MIE; mret restores MIE from MPIE and sets MPIE.
    assign w_mstatus_trap = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
    assign w_mstatus_mret = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};

`ifdef CSR_TRAP_VECTORED_EN
    // Vectored mode offsets interrupts by 4*cause; exceptions always use the base.
    assign w_trap_addr = (r_kind && csr_mtvec_i[1:0] == 2'b01) ? w_base + {r_cause[29:0], 2'b00} : w_base;
`else
    logic w_unused;
    assign w_unused    = ^{csr_mtvec_i[1:0], r_kind};
    assign w_trap_addr = w_base;
`endif

    // Sequencer: accepts one event in IDLE by priority and walks the CSR write/redirect steps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cause <= '0;
            r_epc   <= '0;
            r_kind  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ecall_i) begin
                        r_cause <= ECALL_CAUSE;
                        r_epc   <= inst_addr_i;
                        r_kind  <= 1'b0;
                        r_state <= S_W_MEPC;
                    end else if (ebreak_i) begin
                        r_cause <= EBREAK_CAUSE;
                        r_epc   <= inst_addr_i;
                        r_kind  <= 1'b0;
                        r_state <= S_W_MEPC;
                    end else if (mret_i) begin
                        r_state <= S_MRET_MSTATUS;
                    end else if (w_int) begin
                        r_cause <= TIMER_CAUSE;
                        r_epc   <= jump_flag_i ? jump_addr_i : inst_addr_i;
                        r_kind  <= 1'b1;
                        r_state <= S_W_MEPC;
                    end
                end
                S_W_MEPC:       r_state <= S_W_MSTATUS;
                S_W_MSTATUS:    r_state <= S_W_MCAUSE;
                S_W_MCAUSE:     r_state <= S_ASSERT;
                S_MRET_MSTATUS: r_state <= S_MRET_ASSERT;
                default:        r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode from state; the IDLE stall is raised the same cycle an event is seen.
    always_comb begin
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        hold_o       = ~w_idle | (~rst_i & w_detect);
        case (r_state)
            S_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = A_MEPC;
                csr_wdata_o = r_epc;
            end
            S_W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = A_MSTATUS;
                csr_wdata_o = w_mstatus_trap;
            end
            S_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = A_MCAUSE;
                csr_wdata_o = r_cause;
            end
            S_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = w_trap_addr;
            end
            S_MRET_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = A_MSTATUS;
                csr_wdata_o = w_mstatus_mret;
            end
            S_MRET_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
            end
            default: ;
        endcase
    end

endmodule
